// File: rtl/beep_driver.sv
// Buzzer driver: turns level request codes into fixed-length square-wave bursts,
// repeating long beeps with silent gaps while an alarm request is held.
module beep_driver #(
    parameter int unsigned SHORT_HALF = 50000,
    parameter int unsigned LONG_HALF  = 25000,
    parameter int unsigned SHORT_CYC  = 10000000,
    parameter int unsigned LONG_CYC   = 50000000,
    parameter int unsigned GAP_CYC    = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] bee_in,
    output logic       buzz,
    output logic       busy,
    output logic       beep_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHORT,
        S_LONG,
        S_GAP
    } state_t;

    localparam logic [1:0] REQ_SHORT = 2'b01;
    localparam logic [1:0] REQ_LONG  = 2'b10;

    state_t      r_state;
    logic [1:0]  r_bee_q;
    logic [31:0] r_dcnt;
    logic [31:0] r_tcnt;
    logic        r_buzz;
    logic        r_busy;
    logic        r_done;

    logic        w_trig_long;
    logic        w_trig_short;
    logic [31:0] w_half;

    // Edge detect against last cycle's code so a held level never retriggers.
    assign w_trig_long  = (bee_in == REQ_LONG)  && (r_bee_q != REQ_LONG);
    assign w_trig_short = (bee_in == REQ_SHORT) && (r_bee_q != REQ_SHORT);
    assign w_half       = (r_state == S_LONG) ? LONG_HALF : SHORT_HALF;

    // NOTE: sequential state uses non-blocking assignments only; the reset is
    // synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bee_q <= 2'b00;
            r_dcnt  <= '0;
            r_tcnt  <= '0;
            r_buzz  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_bee_q <= bee_in;
            r_done  <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
                r_dcnt  <= '0;
                r_tcnt  <= '0;
                r_buzz  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dcnt <= '0;
                        r_tcnt <= '0;
                        if (w_trig_long) begin
                            r_state <= S_LONG;
                            r_buzz  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_trig_short) begin
                            r_state <= S_SHORT;
                            r_buzz  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_buzz  <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_SHORT: begin
                        // Preemption wins over completion, so no done pulse here.
                        if (w_trig_long) begin
                            r_state <= S_LONG;
                            r_dcnt  <= '0;
                            r_tcnt  <= '0;
                            r_buzz  <= 1'b1;
                        end else if (r_dcnt == SHORT_CYC - 1) begin
                            r_state <= S_IDLE;
                            r_dcnt  <= '0;
                            r_tcnt  <= '0;
                            r_buzz  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + 32'd1;
                            if (r_tcnt == w_half - 1) begin
                                r_tcnt <= '0;
                                r_buzz <= ~r_buzz;
                            end else begin
                                r_tcnt <= r_tcnt + 32'd1;
                            end
                        end
                    end
                    S_LONG: begin
                        if (r_dcnt == LONG_CYC - 1) begin
                            r_done  <= 1'b1;
                            r_dcnt  <= '0;
                            r_tcnt  <= '0;
                            r_buzz  <= 1'b0;
                            if (bee_in == REQ_LONG) begin
                                r_state <= S_GAP;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_dcnt <= r_dcnt + 32'd1;
                            if (r_tcnt == w_half - 1) begin
                                r_tcnt <= '0;
                                r_buzz <= ~r_buzz;
                            end else begin
                                r_tcnt <= r_tcnt + 32'd1;
                            end
                        end
                    end
                    default: begin
                        // GAP: a short request interrupts, dropping the alarm ends it.
                        r_tcnt <= '0;
                        if (bee_in == REQ_SHORT) begin
                            r_state <= S_SHORT;
                            r_dcnt  <= '0;
                            r_buzz  <= 1'b1;
                        end else if (bee_in != REQ_LONG) begin
                            r_state <= S_IDLE;
                            r_dcnt  <= '0;
                            r_buzz  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else if (r_dcnt == GAP_CYC - 1) begin
                            r_state <= S_LONG;
                            r_dcnt  <= '0;
                            r_buzz  <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + 32'd1;
                            r_buzz <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign buzz      = r_buzz;
    assign busy      = r_busy;
    assign beep_done = r_done;

endmodule
